// File: rtl/ripple_count_sampler_pkg.sv
// rtl/ripple_count_sampler_pkg.sv - shared FSM states and default parameters for ripple_count_sampler
package ripple_count_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WID_COUNT  = 6;
  localparam int DEF_WID_ACC    = 12;
  localparam int DEF_WIN_CYCLES = 256;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ripple_count_sync.sv
// rtl/ripple_count_sync.sv - 2-flop synchronizer and accept stage for the ripple count
// Optional glitch filter under RIPPLE_COUNT_SAMPLER_FILTER_EN.
module ripple_count_sync
  import ripple_count_sampler_pkg::*;
#(
  parameter int WID_COUNT = DEF_WID_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WID_COUNT-1:0] count_in,
  output logic [WID_COUNT-1:0] stable,
  output logic                 update
);

  logic [WID_COUNT-1:0] sync1;
  logic [WID_COUNT-1:0] sync2;
  logic                 accept;

`ifdef RIPPLE_COUNT_SAMPLER_FILTER_EN
  // A value must be seen on two consecutive cycles before it is trusted.
  logic [WID_COUNT-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync2_q <= '0;
    end else begin
      sync2_q <= sync2;
    end
  end

  assign accept = (sync2 == sync2_q);
`else
  assign accept = 1'b1;
`endif

  // update is high in the cycle after stable took a new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      update <= 1'b0;
    end else begin
      sync1  <= count_in;
      sync2  <= sync1;
      update <= accept && (sync2 != stable);
      if (accept) begin
        stable <= sync2;
      end
    end
  end

endmodule

// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - windowed count measurement of an asynchronous ripple counter
// Glitch filter selected by RIPPLE_COUNT_SAMPLER_FILTER_EN (see ripple_count_sync).
module ripple_count_sampler
  import ripple_count_sampler_pkg::*;
#(
  parameter int WID_COUNT  = DEF_WID_COUNT,
  parameter int WID_ACC    = DEF_WID_ACC,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WID_COUNT-1:0] count_in,
  output logic                 busy,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic [WID_ACC-1:0]   meas_count,
  output logic                 meas_sat
);

  localparam int TW = $clog2(WIN_CYCLES);
  localparam int SW = max_int(WID_ACC, WID_COUNT) + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(SW-WID_ACC){1'b0}}, {WID_ACC{1'b1}}};

  state_t               state;
  state_t               state_next;
  logic [WID_COUNT-1:0] stable;
  logic                 update;
  logic [WID_COUNT-1:0] prev;
  logic [WID_COUNT-1:0] diff;
  logic [WID_ACC-1:0]   acc;
  logic                 sat;
  logic [TW-1:0]        timer;
  logic [SW-1:0]        sum;
  logic                 win_end;

  ripple_count_sync #(
    .WID_COUNT(WID_COUNT)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .count_in(count_in),
    .stable  (stable),
    .update  (update)
  );

  // Truncation to WID_COUNT makes the difference wrap modulo 2^WID_COUNT.
  assign diff    = stable - prev;
  assign sum     = SW'(acc) + SW'(diff);
  assign win_end = (timer == TW'(WIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    meas_valid = 1'b0;
    meas_count = '0;
    meas_sat   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MEAS;
        end
      end
      MEAS: begin
        busy = 1'b1;
        if (win_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        meas_valid = 1'b1;
        meas_count = acc;
        meas_sat   = sat;
        if (meas_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      acc   <= '0;
      sat   <= 1'b0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            prev  <= stable;
            acc   <= '0;
            sat   <= 1'b0;
            timer <= '0;
          end
        end
        MEAS: begin
          timer <= timer + 1'b1;
          if (update) begin
            prev <= stable;
            if (sum > ACC_MAX) begin
              acc <= '1;
              sat <= 1'b1;
            end else begin
              acc <= sum[WID_ACC-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb/tb_ripple_count_sampler.sv - randomized self-checking bench for ripple_count_sampler
// Model follows RIPPLE_COUNT_SAMPLER_FILTER_EN when defined.
module tb_ripple_count_sampler;

  localparam int WC  = 6;
  localparam int WA  = 12;
  localparam int WS  = 4;
  localparam int WIN = 16;
  localparam int MAX_A = (1 << WA) - 1;
  localparam int MAX_S = (1 << WS) - 1;

`ifdef RIPPLE_COUNT_SAMPLER_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          meas_ready;
  logic [WC-1:0] count_in;
  logic          busy, meas_valid, meas_sat;
  logic [WA-1:0] meas_count;
  logic          busy_s, meas_valid_s, meas_sat_s;
  logic [WS-1:0] meas_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_count_sampler #(.WID_COUNT(WC), .WID_ACC(WA), .WIN_CYCLES(WIN)) u_dut (
    .clk(clk), .rst(rst), .start(start), .count_in(count_in),
    .busy(busy), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_count(meas_count), .meas_sat(meas_sat)
  );

  ripple_count_sampler #(.WID_COUNT(WC), .WID_ACC(WS), .WIN_CYCLES(WIN)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start), .count_in(count_in),
    .busy(busy_s), .meas_valid(meas_valid_s), .meas_ready(meas_ready),
    .meas_count(meas_count_s), .meas_sat(meas_sat_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expand the stimulus into a per-cycle trace, accept values by the filter
  // rule and sum the wrapped differences between accepted values.
  function automatic int model_total(input int init, input int vals[$], input int holds[$]);
    int trace[$];
    int total = 0;
    int cur = init;
    trace.push_back(init);
    trace.push_back(init);
    foreach (vals[i])
      for (int k = 0; k < holds[i]; k++) trace.push_back(vals[i]);
    trace.push_back(trace[trace.size()-1]);
    trace.push_back(trace[trace.size()-1]);
    for (int i = 1; i < trace.size(); i++) begin
      if (!FILT || trace[i] == trace[i-1]) begin
        total += (trace[i] - cur + 64) % 64;
        cur = trace[i];
      end
    end
    return total;
  endfunction

  task automatic check_result(input string tag, input int total);
    check({tag, "_cnt"},   meas_count,   (total > MAX_A) ? MAX_A : total);
    check({tag, "_sat"},   meas_sat,     total > MAX_A);
    check({tag, "_cnt4"},  meas_count_s, (total > MAX_S) ? MAX_S : total);
    check({tag, "_sat4"},  meas_sat_s,   total > MAX_S);
    check({tag, "_vld4"},  meas_valid_s, 1);
  endtask

  task automatic handshake(input string tag);
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_cnt"},  meas_count, 0);
  endtask

  task automatic run_window(input string tag, input int init, input int vals[$],
                            input int holds[$], input int stall);
    int n = 0;
    int total;
    count_in = WC'(init);
    repeat (6) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_meas_busy"}, busy, 1);
    check({tag, "_meas_zero"}, meas_count, 0);
    foreach (vals[i]) begin
      count_in = WC'(vals[i]);
      repeat (holds[i]) begin
        step();
        n++;
      end
    end
    while (!meas_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, WIN);
    total = model_total(init, vals, holds);
    check_result(tag, total);
    for (int i = 0; i < stall; i++) begin
      start = (i % 2 == 0);
      count_in = WC'($urandom_range(0, 63));
      step();
      check({tag, "_hold_vld"}, meas_valid, 1);
      check({tag, "_hold_cnt"}, meas_count, (total > MAX_A) ? MAX_A : total);
      check({tag, "_hold_sat4"}, meas_sat_s, total > MAX_S);
    end
    start = 1'b0;
    handshake(tag);
  endtask

  // Continuous ramp: any 16-cycle window sees exactly four steps.
  task automatic run_ramp(input string tag, input int stp, input int phase);
    int v = $urandom_range(0, 63);
    int c = 0;
    int n = -1;
    count_in = WC'(v);
    while (!meas_valid && c < 80) begin
      start = (c == 8 + phase);
      if (c > 0 && c % 4 == 0) begin
        v = (v + stp) % 64;
        count_in = WC'(v);
      end
      step();
      c++;
      if (c - 1 == 8 + phase) n = 0;
      else if (n >= 0) n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, WIN);
    check_result(tag, 4 * stp);
    handshake(tag);
  endtask

  initial begin
    int vq[$];
    int hq[$];
    bit seen;

    rst = 1'b1;
    start = 1'b0;
    meas_ready = 1'b0;
    count_in = WC'(5);
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_cnt", meas_count, 0);
    check("rst_sat", meas_sat, 0);
    check("rst_busy4", busy_s, 0);
    check("rst_valid4", meas_valid_s, 0);
    rst = 1'b0;
    step();

    run_ramp("steady", 1, $urandom_range(0, 3));
    run_ramp("steady2", 1, $urandom_range(0, 3));

    vq = {63, 0, 1};
    hq = {3, 3, 3};
    run_window("wrap", 62, vq, hq, 0);

    vq = {45, 10};
    hq = {1, 6};
    run_window("glitch", 10, vq, hq, 0);

    run_ramp("satur", 5, $urandom_range(0, 3));

    vq = {20, 30};
    hq = {3, 3};
    run_window("stall", 7, vq, hq, 10);

    for (int t = 0; t < 6; t++) begin
      int ns;
      vq.delete();
      hq.delete();
      ns = $urandom_range(1, 3);
      for (int s = 0; s < ns; s++) begin
        vq.push_back($urandom_range(0, 63));
        hq.push_back($urandom_range(1, 3));
      end
      run_window($sformatf("rand%0d", t), $urandom_range(0, 63), vq, hq, 0);
    end

    count_in = WC'(3);
    repeat (6) step();
    start = 1'b1;
    step();
    start = 1'b0;
    count_in = WC'(9);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", meas_valid, 0);
    check("midrst_cnt", meas_count, 0);
    seen = 1'b0;
    repeat (25) begin
      step();
      if (meas_valid || meas_valid_s) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
